// File: rtl/shared_bus_pkg.sv
// ---------------------------------------------------------------------------
// shared_bus_pkg
//   Shared definitions for the shared_bus interconnect. It holds the active-low
//   signal levels, the read/write and reset encodings, the bus widths, the
//   master/slave counts, and the owner and slave-index encodings.
// ---------------------------------------------------------------------------
package shared_bus_pkg;

  // Active-low control levels. Every signal whose name ends in '_' uses these.
  localparam logic ENABLE_       = 1'b0;
  localparam logic DISABLE_      = 1'b1;

  localparam logic READ          = 1'b1;
  localparam logic WRITE         = 1'b0;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic RESET_DISABLE = 1'b0;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int SLV_IDX_W   = 3;
  localparam int NUM_MASTERS = 4;
  localparam int NUM_SLAVES  = 1 << SLV_IDX_W;

  typedef enum logic [1:0] {
    BUS_OWNER_M0 = 2'd0,
    BUS_OWNER_M1 = 2'd1,
    BUS_OWNER_M2 = 2'd2,
    BUS_OWNER_M3 = 2'd3
  } bus_owner_t;

  typedef enum logic [SLV_IDX_W-1:0] {
    BUS_SLAVE_0 = 3'd0,
    BUS_SLAVE_1 = 3'd1,
    BUS_SLAVE_2 = 3'd2,
    BUS_SLAVE_3 = 3'd3,
    BUS_SLAVE_4 = 3'd4,
    BUS_SLAVE_5 = 3'd5,
    BUS_SLAVE_6 = 3'd6,
    BUS_SLAVE_7 = 3'd7
  } bus_slave_t;

endpackage

// File: rtl/shared_bus_if.sv
// ---------------------------------------------------------------------------
// shared_bus_if
//   Holds every bus signal of the 4-master / 8-slave shared bus.
//   Master i uses index i of the m_* vectors, and slave k uses index k of the
//   s_cs_/s_rd_data/s_rdy_ vectors.
//   Modports:
//     master : the view of the bus masters (request, address phase, write data)
//     slave  : the view of the bus slaves (shared address phase, chip select)
//     fabric : the view of the interconnect (the shared_bus top)
// ---------------------------------------------------------------------------
interface shared_bus_if;
  import shared_bus_pkg::*;

  // Master side
  logic [NUM_MASTERS-1:0]                  m_req_;
  logic [NUM_MASTERS-1:0]                  m_grnt_;
  logic [NUM_MASTERS-1:0][WORD_ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0]                  m_as_;
  logic [NUM_MASTERS-1:0]                  m_rw;
  logic [NUM_MASTERS-1:0][WORD_DATA_W-1:0] m_wr_data;
  logic [WORD_DATA_W-1:0]                  m_rd_data;
  logic                                    m_rdy_;

  // Slave side
  logic [WORD_ADDR_W-1:0]                  s_addr;
  logic                                    s_as_;
  logic                                    s_rw;
  logic [WORD_DATA_W-1:0]                  s_wr_data;
  logic [NUM_SLAVES-1:0]                   s_cs_;
  logic [NUM_SLAVES-1:0][WORD_DATA_W-1:0]  s_rd_data;
  logic [NUM_SLAVES-1:0]                   s_rdy_;

  modport master (
    output m_req_, m_addr, m_as_, m_rw, m_wr_data,
    input  m_grnt_, m_rd_data, m_rdy_
  );

  modport slave (
    input  s_addr, s_as_, s_rw, s_wr_data, s_cs_,
    output s_rd_data, s_rdy_
  );

  modport fabric (
    input  m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
    output m_grnt_, m_rd_data, m_rdy_, s_addr, s_as_, s_rw, s_wr_data, s_cs_
  );

endinterface

// File: rtl/shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// shared_bus_arbiter
//   Round-robin bus arbiter with a 2-bit owner register.
//   The current owner keeps the bus for as long as it requests it; the bus is
//   never taken away from a requesting owner. When the owner releases, the
//   search for the next owner starts at owner+1 and wraps. When nobody
//   requests, the owner does not change. Reset makes master 0 the owner.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-high reset
//     req_   in   active-low bus requests, one bit per master
//     owner  out  current owner
//     grnt_  out  active-low grants. This is a one-cold decode of owner.
// ---------------------------------------------------------------------------
module shared_bus_arbiter
  import shared_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_,
  output bus_owner_t             owner,
  output logic [NUM_MASTERS-1:0] grnt_
);

  bus_owner_t owner_nxt;
  logic       found;
  logic [1:0] cand_idx;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the edge and no simulation race
  // depends on process ordering.
  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE) begin
      owner <= BUS_OWNER_M0;
    end else begin
      owner <= owner_nxt;
    end
  end

  // NOTE: each variable gets a default at the top of the block. As a result,
  // no path leaves a variable unassigned, and no latch is inferred.
  always_comb begin
    owner_nxt = owner;
    found     = 1'b0;
    cand_idx  = 2'(owner);
    if (req_[owner] == DISABLE_) begin
      // The 2-bit add wraps modulo 4. The first match found going upward
      // from owner+1 becomes the new owner.
      for (int i = 1; i < NUM_MASTERS; i++) begin
        cand_idx = 2'(owner) + 2'(i);
        if (!found && req_[cand_idx] == ENABLE_) begin
          owner_nxt = bus_owner_t'(cand_idx);
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grnt_        = '1;
    grnt_[owner] = ENABLE_;
  end

endmodule

// File: rtl/shared_bus.sv
// ---------------------------------------------------------------------------
// shared_bus
//   Shared-bus interconnect with 4 masters and 8 slaves. A round-robin arbiter
//   picks one owner. The owner's address phase and write data drive the shared
//   slave bus. The top SLV_IDX_W address bits pick one slave chip select. That
//   slave's read data and ready go back to all masters.
//   Ports:
//     clk    in      system clock
//     reset  in      synchronous, active-high reset
//     bus    fabric  shared_bus_if. It carries the master requests and grants,
//                    the shared address phase, the chip selects and the read
//                    return path.
//   Build option:
//     BUS_CS_GATE_EN  When defined, a chip select is asserted only while the
//                     shared s_as_ is enabled. When it is undefined, the chip
//                     selects come from the address bits alone.
// ---------------------------------------------------------------------------
module shared_bus
  import shared_bus_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  shared_bus_if.fabric bus
);

  bus_owner_t             owner;
  logic [NUM_MASTERS-1:0] grnt_;

  logic [WORD_ADDR_W-1:0] s_addr;
  logic                   s_as_;
  logic                   s_rw;
  logic [WORD_DATA_W-1:0] s_wr_data;
  bus_slave_t             slv_idx;
  logic [NUM_SLAVES-1:0]  s_cs_;
  logic [WORD_DATA_W-1:0] m_rd_data;
  logic                   m_rdy_;

  shared_bus_arbiter u_arbiter (
    .clk   (clk),
    .reset (reset),
    .req_  (bus.m_req_),
    .owner (owner),
    .grnt_ (grnt_)
  );

  // Master mux: the owner drives the shared slave-side bus.
  always_comb begin
    s_addr    = bus.m_addr[owner];
    s_as_     = bus.m_as_[owner];
    s_rw      = bus.m_rw[owner];
    s_wr_data = bus.m_wr_data[owner];
  end

  // Address decoder: the top address bits give the slave index.
  always_comb begin
    slv_idx = bus_slave_t'(s_addr[WORD_ADDR_W-1 -: SLV_IDX_W]);
    s_cs_   = '1;
`ifdef BUS_CS_GATE_EN
    if (s_as_ == ENABLE_) begin
      s_cs_[slv_idx] = ENABLE_;
    end
`else
    s_cs_[slv_idx] = ENABLE_;
`endif
  end

  // Slave mux: return the selected slave's data and ready. When no chip select
  // is active (possible only with the gated build), drive zero data and not-ready.
  always_comb begin
    m_rd_data = '0;
    m_rdy_    = DISABLE_;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_cs_[k] == ENABLE_) begin
        m_rd_data = bus.s_rd_data[k];
        m_rdy_    = bus.s_rdy_[k];
      end
    end
  end

  assign bus.m_grnt_   = grnt_;
  assign bus.s_addr    = s_addr;
  assign bus.s_as_     = s_as_;
  assign bus.s_rw      = s_rw;
  assign bus.s_wr_data = s_wr_data;
  assign bus.s_cs_     = s_cs_;
  assign bus.m_rd_data = m_rd_data;
  assign bus.m_rdy_    = m_rdy_;

endmodule

// File: tb/tb_shared_bus.sv
// ---------------------------------------------------------------------------
// tb_shared_bus
//   Table-driven bench for shared_bus. Each table row gives the reset level,
//   the request pattern and the top address bits of master 1. It also gives
//   the expected owner and the expected selected slave, both computed by hand.
//   A row is applied before a rising edge and checked 1 ns after that edge.
//   A hand-written sequence after the table checks the s_as_ chip-select
//   gating for the build in use.
// ---------------------------------------------------------------------------
module tb_shared_bus;
  import shared_bus_pkg::*;

  logic clk;
  logic reset;

  shared_bus_if bus ();

  shared_bus dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req_;     // bit i = master i, active low
    logic [2:0] m1_top;   // top address bits of master 1
    logic [1:0] exp_owner;
    logic [2:0] exp_slv;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_SLAVES-1:0] rdy_pattern;   // odd slaves ready
  logic [NUM_SLAVES-1:0] exp_cs_;
  logic [WORD_DATA_W-1:0] slv_data [NUM_SLAVES];
  logic [WORD_ADDR_W-1:0] mst_addr [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] rw_pattern;
  logic [WORD_DATA_W-1:0] mst_wdata [NUM_MASTERS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_m1_top(input logic [2:0] top);
    mst_addr[1]    = {top, 27'h111_1111};
    bus.m_addr[1]  = mst_addr[1];
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] own, input logic [2:0] slv);
    logic [3:0] exp_grnt;
    exp_grnt      = 4'b1111;
    exp_grnt[own] = 1'b0;
    exp_cs_       = 8'hFF;
    exp_cs_[slv]  = 1'b0;
    check({tag, " grnt_"},     32'(bus.m_grnt_),  32'(exp_grnt));
    check({tag, " s_addr"},    32'(bus.s_addr),   32'(mst_addr[own]));
    check({tag, " s_rw"},      32'(bus.s_rw),     32'(rw_pattern[own]));
    check({tag, " s_wr_data"}, bus.s_wr_data,     mst_wdata[own]);
    check({tag, " s_cs_"},     32'(bus.s_cs_),    32'(exp_cs_));
    check({tag, " m_rd_data"}, bus.m_rd_data,     slv_data[slv]);
    check({tag, " m_rdy_"},    32'(bus.m_rdy_),   32'(rdy_pattern[slv]));
  endtask

  initial begin
    // Fixed master and slave stimulus
    rdy_pattern = 8'b0101_0101;
    rw_pattern  = 4'b0101;
    mst_addr[0] = 30'h0000_0000;
    mst_addr[1] = {3'b001, 27'h111_1111};
    mst_addr[2] = {3'b010, 27'h222_2222};
    mst_addr[3] = {3'b011, 27'h333_3333};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mst_wdata[i]      = 32'hDA7A_0000 + 32'(i);
      bus.m_addr[i]     = mst_addr[i];
      bus.m_wr_data[i]  = mst_wdata[i];
      bus.m_rw[i]       = rw_pattern[i];
      bus.m_as_[i]      = ENABLE_;
    end
    for (int k = 0; k < NUM_SLAVES; k++) begin
      slv_data[k]        = 32'hC0DE_0000 + 32'(k * 32'h11);
      bus.s_rd_data[k]   = slv_data[k];
    end
    bus.s_rdy_ = rdy_pattern;
    bus.m_req_ = 4'b1111;
    reset      = 1'b1;

    //           rst   req_     m1_top owner slv
    vecs[0]  = '{1'b1, 4'b1111, 3'd1, 2'd0, 3'd0}; // reset, idle
    vecs[1]  = '{1'b1, 4'b1111, 3'd1, 2'd0, 3'd0};
    vecs[2]  = '{1'b0, 4'b1100, 3'd1, 2'd0, 3'd0}; // m0,m1 request: m0 keeps
    vecs[3]  = '{1'b0, 4'b1100, 3'd1, 2'd0, 3'd0};
    vecs[4]  = '{1'b0, 4'b1101, 3'd1, 2'd1, 3'd1}; // m0 drops -> m1
    vecs[5]  = '{1'b0, 4'b0000, 3'd1, 2'd1, 3'd1}; // all request: m1 holds
    vecs[6]  = '{1'b0, 4'b0010, 3'd1, 2'd2, 3'd2}; // m1 releases -> m2, not m0
    vecs[7]  = '{1'b0, 4'b1110, 3'd1, 2'd0, 3'd0}; // m2 releases, m0 only -> wrap
    vecs[8]  = '{1'b0, 4'b1111, 3'd1, 2'd0, 3'd0}; // nobody requests: stays
    vecs[9]  = '{1'b0, 4'b1101, 3'd1, 2'd1, 3'd1};
    vecs[10] = '{1'b1, 4'b1101, 3'd1, 2'd0, 3'd0}; // reset while m1 owns
    vecs[11] = '{1'b0, 4'b1101, 3'd1, 2'd1, 3'd1};
    vecs[12] = '{1'b0, 4'b1101, 3'd0, 2'd1, 3'd0}; // slave sweep through m1
    vecs[13] = '{1'b0, 4'b1101, 3'd1, 2'd1, 3'd1};
    vecs[14] = '{1'b0, 4'b1101, 3'd2, 2'd1, 3'd2};
    vecs[15] = '{1'b0, 4'b1101, 3'd3, 2'd1, 3'd3};
    vecs[16] = '{1'b0, 4'b1101, 3'd4, 2'd1, 3'd4};
    vecs[17] = '{1'b0, 4'b1101, 3'd5, 2'd1, 3'd5};
    vecs[18] = '{1'b0, 4'b1101, 3'd6, 2'd1, 3'd6};
    vecs[19] = '{1'b0, 4'b1101, 3'd7, 2'd1, 3'd7};
    vecs[20] = '{1'b0, 4'b0111, 3'd1, 2'd3, 3'd3}; // only m3 -> m3
    vecs[21] = '{1'b0, 4'b0101, 3'd1, 2'd3, 3'd3}; // m3 holds against m1
    vecs[22] = '{1'b0, 4'b1101, 3'd1, 2'd1, 3'd1}; // m3 drops, wrap 0 -> 1

    for (int i = 0; i < NVEC; i++) begin
      reset      = vecs[i].rst;
      bus.m_req_ = vecs[i].req_;
      set_m1_top(vecs[i].m1_top);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_owner, vecs[i].exp_slv);
    end

    // Address-strobe gating, with master 1 owning the bus and addressing slave 5
    set_m1_top(3'd5);
    bus.m_as_[1] = DISABLE_;
    #1;
    check("gate s_as_ off", 32'(bus.s_as_), 32'(DISABLE_));
`ifdef BUS_CS_GATE_EN
    check("gate cs_ off",      32'(bus.s_cs_),  32'hFF);
    check("gate m_rdy_ off",   32'(bus.m_rdy_), 32'(DISABLE_));
    check("gate m_rd_data off", bus.m_rd_data,  32'h0);
`else
    check("nogate cs_",        32'(bus.s_cs_),  32'hDF);
    check("nogate m_rdy_",     32'(bus.m_rdy_), 32'(ENABLE_));
    check("nogate m_rd_data",  bus.m_rd_data,   32'hC0DE_0055);
`endif
    bus.m_as_[1] = ENABLE_;
    #1;
    check("strobe on s_as_",     32'(bus.s_as_), 32'(ENABLE_));
    check("strobe on cs_",       32'(bus.s_cs_), 32'hDF);
    check("strobe on m_rdy_",    32'(bus.m_rdy_), 32'(ENABLE_));
    check("strobe on m_rd_data", bus.m_rd_data,  32'hC0DE_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
